// File: rtl/eth_tx.sv
// RMII transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS and inter-frame gap.
// One byte per 4 Clk cycles, dibits LSB first. Every output comes from a flop.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   sIdle     | line quiet, waiting for Tx_Valid
//   sPreamble | 7 bytes of 0x55
//   sSfd      | 0xD5; first payload byte requested on its last dibit
//   sData     | payload bytes from upstream, one handshake per byte
//   sPad      | 0x00 bytes until the minimum frame length is reached
//   sFcs      | complemented CRC, least-significant byte first
//   sIfg      | inter-frame gap, line quiet, upstream ignored
module eth_tx #(
   parameter int pMIN_FRAME = 60,
   parameter int pIFG_BYTES = 12
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tx_Valid,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_Last,
   output logic       Tx_Ready,
   output logic       Tx_En,
   output logic [1:0] Txd,
   output logic       Tx_Busy,
   output logic       Tx_Underrun
);

   localparam int          cMinInt   = (pMIN_FRAME > 2047) ? 2047 : pMIN_FRAME;
   localparam logic [10:0] cMinFrame = 11'(cMinInt);
   localparam int          cIfgCyc   = (pIFG_BYTES < 1) ? 1 : pIFG_BYTES * 4;
   localparam logic [15:0] cIfgLoad  = 16'(cIfgCyc - 1);
   localparam logic [31:0] cCrcInit  = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      sIdle, sPreamble, sSfd, sData, sPad, sFcs, sIfg
   } stateT;

   stateT       state;
   logic [1:0]  phase;
   logic [2:0]  byteIdx;
   logic [7:0]  shiftByte;
   logic        curLast;
   logic [10:0] byteCnt;
   logic [31:0] crc;
   logic [15:0] ifgCnt;

   function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ({1'b0, r[31:1]} ^ 32'hEDB8_8320) : {1'b0, r[31:1]};
      end
      return r;
   endfunction

   function automatic logic [10:0] satInc(input logic [10:0] c);
      return (c == 11'h7FF) ? c : c + 11'd1;
   endfunction

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state       <= sIdle;
         phase       <= 2'd0;
         byteIdx     <= 3'd0;
         shiftByte   <= 8'h00;
         curLast     <= 1'b0;
         byteCnt     <= 11'd0;
         crc         <= cCrcInit;
         ifgCnt      <= 16'd0;
         Tx_Ready    <= 1'b0;
         Tx_En       <= 1'b0;
         Txd         <= 2'b00;
         Tx_Busy     <= 1'b0;
         Tx_Underrun <= 1'b0;
      end else begin
         Tx_Underrun <= 1'b0;
         case (state)
            sIdle: begin
               Tx_Ready <= 1'b0;
               Tx_En    <= 1'b0;
               Txd      <= 2'b00;
               if (Tx_Valid) begin
                  state     <= sPreamble;
                  Tx_En     <= 1'b1;
                  Tx_Busy   <= 1'b1;
                  shiftByte <= 8'h55;
                  Txd       <= 2'b01;
                  phase     <= 2'd0;
                  byteIdx   <= 3'd6;
                  byteCnt   <= 11'd0;
                  curLast   <= 1'b0;
                  crc       <= cCrcInit;
               end
            end
            sIfg: begin
               if (ifgCnt == 16'd0) begin
                  state   <= sIdle;
                  Tx_Busy <= 1'b0;
               end else begin
                  ifgCnt <= ifgCnt - 16'd1;
               end
            end
            default: begin
               if (phase != 2'd3) begin
                  phase     <= phase + 2'd1;
                  shiftByte <= {2'b00, shiftByte[7:2]};
                  Txd       <= shiftByte[3:2];
                  // Request the next byte on the last dibit so it follows with no bubble.
                  Tx_Ready  <= (phase == 2'd2) &&
                               ((state == sSfd) || ((state == sData) && !curLast));
               end else begin
                  phase    <= 2'd0;
                  Tx_Ready <= 1'b0;
                  case (state)
                     sPreamble: begin
                        if (byteIdx == 3'd0) begin
                           state     <= sSfd;
                           shiftByte <= 8'hD5;
                           Txd       <= 2'b01;
                        end else begin
                           byteIdx   <= byteIdx - 3'd1;
                           shiftByte <= 8'h55;
                           Txd       <= 2'b01;
                        end
                     end
                     sSfd, sData: begin
                        if (Tx_Ready) begin
                           if (Tx_Valid) begin
                              state     <= sData;
                              shiftByte <= Tx_Data;
                              Txd       <= Tx_Data[1:0];
                              curLast   <= Tx_Last;
                              crc       <= crcByte(crc, Tx_Data);
                              byteCnt   <= satInc(byteCnt);
                           end else begin
                              // Underrun flags alongside the dropped TX_EN, since both are flopped.
                              Tx_Underrun <= 1'b1;
                              Tx_En       <= 1'b0;
                              Txd         <= 2'b00;
                              state       <= sIfg;
                              ifgCnt      <= cIfgLoad;
                              crc         <= cCrcInit;
                           end
                        end else if (byteCnt < cMinFrame) begin
                           state     <= sPad;
                           shiftByte <= 8'h00;
                           Txd       <= 2'b00;
                           crc       <= crcByte(crc, 8'h00);
                           byteCnt   <= satInc(byteCnt);
                        end else begin
                           state     <= sFcs;
                           shiftByte <= ~crc[7:0];
                           Txd       <= ~crc[1:0];
                           crc       <= {8'h00, crc[31:8]};
                           byteIdx   <= 3'd3;
                        end
                     end
                     sPad: begin
                        if (byteCnt < cMinFrame) begin
                           shiftByte <= 8'h00;
                           Txd       <= 2'b00;
                           crc       <= crcByte(crc, 8'h00);
                           byteCnt   <= satInc(byteCnt);
                        end else begin
                           state     <= sFcs;
                           shiftByte <= ~crc[7:0];
                           Txd       <= ~crc[1:0];
                           crc       <= {8'h00, crc[31:8]};
                           byteIdx   <= 3'd3;
                        end
                     end
                     sFcs: begin
                        if (byteIdx == 3'd0) begin
                           state  <= sIfg;
                           Tx_En  <= 1'b0;
                           Txd    <= 2'b00;
                           ifgCnt <= cIfgLoad;
                           crc    <= cCrcInit;
                        end else begin
                           byteIdx   <= byteIdx - 3'd1;
                           shiftByte <= ~crc[7:0];
                           Txd       <= ~crc[1:0];
                           crc       <= {8'h00, crc[31:8]};
                        end
                     end
                     default: begin
                        state <= sIdle;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx.sv
// Directed bench for eth_tx: default instance plus an unpadded instance sharing the same upstream.
module tb_eth_tx;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Tx_Valid = 1'b0;
   logic [7:0] Tx_Data = 8'h00;
   logic       Tx_Last = 1'b0;
   logic       Tx_Ready, Tx_En, Tx_Busy, Tx_Underrun;
   logic [1:0] Txd;
   logic       npReady, npEn, npBusy, npUnder;
   logic [1:0] npTxd;

   int nChecks = 0;
   int nFails  = 0;
   logic [7:0] pay [0:127];

   eth_tx dut (
      .Clk(Clk), .Rst(Rst), .Tx_Valid(Tx_Valid), .Tx_Data(Tx_Data), .Tx_Last(Tx_Last),
      .Tx_Ready(Tx_Ready), .Tx_En(Tx_En), .Txd(Txd), .Tx_Busy(Tx_Busy), .Tx_Underrun(Tx_Underrun)
   );

   eth_tx #(.pMIN_FRAME(0)) dutNp (
      .Clk(Clk), .Rst(Rst), .Tx_Valid(Tx_Valid), .Tx_Data(Tx_Data), .Tx_Last(Tx_Last),
      .Tx_Ready(npReady), .Tx_En(npEn), .Txd(npTxd), .Tx_Busy(npBusy), .Tx_Underrun(npUnder)
   );

   always #10 Clk = ~Clk;

   // line monitors
   logic [7:0] mBytes[$];
   logic [7:0] mByte;
   int mD, mEnCnt, mEnLen, mFrames, mLow, mLastGap, mLowBusy, mGapAtIdle;
   int mReadyCnt, mBadSpacing, mLastReadyCyc, mUnderCnt, mEnTotal, cyc;
   logic mUnderEn, mPrevEn, mPrevBusy;
   logic [7:0] npBytes[$];
   logic [7:0] npByte;
   int npD, npEnCnt, npEnLen, npReadyCnt, npUnderCnt;
   logic npPrevEn;

   task automatic clearMon();
      mBytes.delete(); npBytes.delete();
      mD = 0; mEnCnt = 0; mEnLen = 0; mFrames = 0; mLow = 0; mLastGap = 0;
      mLowBusy = 0; mGapAtIdle = 0; mReadyCnt = 0; mBadSpacing = 0; mLastReadyCyc = 0;
      mUnderCnt = 0; mEnTotal = 0; mUnderEn = 1'b1;
      npD = 0; npEnCnt = 0; npEnLen = 0; npReadyCnt = 0; npUnderCnt = 0;
   endtask

   initial begin
      cyc = 0; mPrevEn = 1'b0; mPrevBusy = 1'b0; npPrevEn = 1'b0;
      mByte = 8'h00; npByte = 8'h00;
      clearMon();
   end

   always @(negedge Clk) begin
      cyc++;
      if (Tx_En === 1'b1) begin
         if (!mPrevEn) begin
            mBytes.delete(); mD = 0; mEnCnt = 0; mLastGap = mLow;
         end
         mByte[2*mD +: 2] = Txd;
         if (mD == 3) begin mBytes.push_back(mByte); mD = 0; end
         else mD++;
         mEnCnt++; mEnTotal++; mLow = 0; mLowBusy = 0;
      end else begin
         if (mPrevEn) begin mFrames++; mEnLen = mEnCnt; end
         mLow++;
         if (Tx_Busy === 1'b1) mLowBusy++;
      end
      if (mPrevBusy && Tx_Busy === 1'b0) mGapAtIdle = mLowBusy;
      if (Tx_Ready === 1'b1) begin
         if (mReadyCnt > 0 && (cyc - mLastReadyCyc) != 4) mBadSpacing++;
         mReadyCnt++; mLastReadyCyc = cyc;
      end
      if (Tx_Underrun === 1'b1) begin mUnderCnt++; mUnderEn = Tx_En; end
      mPrevEn = (Tx_En === 1'b1); mPrevBusy = (Tx_Busy === 1'b1);

      if (npEn === 1'b1) begin
         if (!npPrevEn) begin npBytes.delete(); npD = 0; npEnCnt = 0; end
         npByte[2*npD +: 2] = npTxd;
         if (npD == 3) begin npBytes.push_back(npByte); npD = 0; end
         else npD++;
         npEnCnt++;
      end else if (npPrevEn) begin
         npEnLen = npEnCnt;
      end
      if (npReady === 1'b1) npReadyCnt++;
      if (npUnder === 1'b1) npUnderCnt++;
      npPrevEn = (npEn === 1'b1);
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference CRC over captured line bytes, returned as the on-wire FCS value.
   function automatic logic [31:0] fcsOf(input int first, input int cnt);
      logic [31:0] c;
      logic [7:0]  b;
      logic        fb;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < cnt; i++) begin
         b = mBytes[first + i];
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      end
      return ~c;
   endfunction

   task automatic sendFrame(input int n, input int underAt, input bit keepValid, input bit chkStart);
      int acc = 0;
      int rdy = 0;
      int c   = 0;
      Tx_Valid = 1'b1; Tx_Data = pay[0]; Tx_Last = (n == 1);
      if (chkStart) begin
         @(negedge Clk);
         checkVal("startEn", Tx_En, 1);
         checkVal("startTxd", Txd, 2'b01);
      end
      while (acc < n && c < 5000) begin
         @(negedge Clk); c++;
         if (Tx_Ready === 1'b1) begin
            rdy++;
            if (underAt != 0 && rdy == underAt) break;
            @(posedge Clk); #1;
            acc++;
            if (acc < n) begin
               Tx_Data = pay[acc]; Tx_Last = (acc == n - 1);
               if (underAt != 0 && acc == underAt - 1) Tx_Valid = 1'b0;
            end else if (keepValid) begin
               Tx_Data = pay[0]; Tx_Last = (n == 1);
            end else begin
               Tx_Valid = 1'b0; Tx_Last = 1'b0;
            end
         end
      end
      checkVal("sendInTime", (c < 5000), 1);
   endtask

   task automatic waitIdle();
      int c = 0;
      @(negedge Clk);
      while (Tx_Busy === 1'b1 && c < 2000) begin @(negedge Clk); c++; end
      checkVal("idleInTime", (c < 2000), 1);
      #1;
   endtask

   task automatic chkMainFrame(input int n);
      int total = (n < 60) ? 60 : n;
      int errs;
      checkVal("frameBytes", mBytes.size(), 8 + total + 4);
      errs = 0;
      for (int i = 0; i < 7; i++) if (mBytes[i] !== 8'h55) errs++;
      checkVal("preamble", errs, 0);
      checkVal("sfd", mBytes[7], 8'hD5);
      errs = 0;
      for (int i = 0; i < n; i++) if (mBytes[8 + i] !== pay[i]) errs++;
      checkVal("payload", errs, 0);
      errs = 0;
      for (int i = n; i < total; i++) if (mBytes[8 + i] !== 8'h00) errs++;
      checkVal("padZero", errs, 0);
      checkVal("fcs", {mBytes[total + 11], mBytes[total + 10], mBytes[total + 9], mBytes[total + 8]},
               fcsOf(8, total));
      checkVal("enLen", mEnLen, 4 * (12 + total));
   endtask

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs;
      int c;
      #2 Rst = 1'b0;
      repeat (3) @(negedge Clk);
      checkVal("rstEn", Tx_En, 0);
      checkVal("rstTxd", Txd, 0);
      checkVal("rstReady", Tx_Ready, 0);
      checkVal("rstBusy", Tx_Busy, 0);
      checkVal("rstUnder", Tx_Underrun, 0);
      @(posedge Clk); #1 Rst = 1'b1;
      repeat (3) @(negedge Clk); #1;
      clearMon();

      // "123456789": unpadded instance gives the well-known check value
      for (int i = 0; i < 9; i++) pay[i] = 8'(8'h31 + i);
      sendFrame(9, 0, 0, 1);
      waitIdle();
      checkVal("npBytes", npBytes.size(), 21);
      errs = 0;
      for (int i = 0; i < 7; i++) if (npBytes[i] !== 8'h55) errs++;
      checkVal("npPreamble", errs, 0);
      checkVal("npSfd", npBytes[7], 8'hD5);
      errs = 0;
      for (int i = 0; i < 9; i++) if (npBytes[8 + i] !== pay[i]) errs++;
      checkVal("npPayload", errs, 0);
      checkVal("npFcs", {npBytes[20], npBytes[19], npBytes[18], npBytes[17]}, 32'hCBF4_3926);
      checkVal("npEnLen", npEnLen, 84);
      checkVal("npReadyCnt", npReadyCnt, 9);
      checkVal("npUnder", npUnderCnt, 0);
      checkVal("npBusy", npBusy, 0);
      chkMainFrame(9);
      checkVal("readyCnt9", mReadyCnt, 9);
      checkVal("ifgGap9", mGapAtIdle, 48);

      // 14-byte payload padded to 60
      clearMon();
      for (int i = 0; i < 14; i++) pay[i] = 8'(8'hA0 + 8'(i * 7));
      sendFrame(14, 0, 0, 1);
      waitIdle();
      chkMainFrame(14);
      checkVal("ifgGap14", mGapAtIdle, 48);

      // 64-byte payload, no padding
      clearMon();
      for (int i = 0; i < 64; i++) pay[i] = 8'(i * 3 + 5);
      sendFrame(64, 0, 0, 1);
      waitIdle();
      chkMainFrame(64);
      checkVal("readyCnt64", mReadyCnt, 64);
      checkVal("readySpacing", mBadSpacing, 0);

      // underrun at the 5th request
      clearMon();
      for (int i = 0; i < 10; i++) pay[i] = 8'(8'h10 + i);
      sendFrame(10, 5, 0, 1);
      waitIdle();
      checkVal("underCnt", mUnderCnt, 1);
      checkVal("underEnLow", mUnderEn, 0);
      checkVal("underBytes", mBytes.size(), 12);
      checkVal("underEnLen", mEnLen, 48);
      checkVal("underReady", mReadyCnt, 5);
      checkVal("underIfg", mGapAtIdle, 48);

      // reset during FCS, then two back-to-back frames
      clearMon();
      for (int i = 0; i < 14; i++) pay[i] = 8'(8'hC3 ^ i);
      sendFrame(14, 0, 0, 1);
      c = 0;
      while (mBytes.size() < 69 && c < 1000) begin @(negedge Clk); #1; c++; end
      checkVal("reachFcs", (c < 1000), 1);
      Rst = 1'b0;
      #1;
      checkVal("midRstEn", Tx_En, 0);
      checkVal("midRstTxd", Txd, 0);
      checkVal("midRstBusy", Tx_Busy, 0);
      checkVal("midRstReady", Tx_Ready, 0);
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b1;
      clearMon();
      repeat (20) @(negedge Clk);
      #1;
      checkVal("quietAfterRst", mEnTotal, 0);
      checkVal("idleAfterRst", Tx_Busy, 0);
      clearMon();
      sendFrame(14, 0, 1, 1);
      sendFrame(14, 0, 0, 0);
      waitIdle();
      checkVal("b2bFrames", mFrames, 2);
      checkVal("b2bGap", mLastGap, 49);
      chkMainFrame(14);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/eth_tx.md
ETH_TX -- requirements
Module: eth_tx

Interface
REQ-001 Design SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter pMIN_FRAME, 60, minimum payload+pad byte count before FCS; 0 disables padding.
REQ-003 Parameter pIFG_BYTES, 12, inter-frame gap length in byte times (4 clocks each).
REQ-004 Port Clk  input  1  50 MHz RMII reference clock; all logic on rising edge.
REQ-005 Port Rst  input  1  asynchronous active-low reset.
REQ-006 Port Tx_Valid  input  1  upstream byte available on Tx_Data.
REQ-007 Port Tx_Data  input  8  payload byte (dest MAC first).
REQ-008 Port Tx_Last  input  1  qualifies Tx_Data as final payload byte.
REQ-009 Port Tx_Ready  output  1  byte accepted when Tx_Valid & Tx_Ready at a rising edge.
REQ-010 Port Tx_En  output  1  RMII TX_EN to PHY.
REQ-011 Port Txd  output  2  RMII TXD[1:0] to PHY.
REQ-012 Port Tx_Busy  output  1  high in any state other than IDLE.
REQ-013 Port Tx_Underrun  output  1  one-cycle pulse on frame abort.

Function
REQ-014 States SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-015 All outputs SHALL be registered; each byte occupies exactly 4 clocks, dibits LSB first (bits[1:0] first, bits[7:6] last).
REQ-016 IDLE: Tx_En=0, Txd=00; Tx_Valid sampled high -> PREAMBLE, first preamble dibit on Tx_En/Txd one cycle later; byte not consumed in IDLE.
REQ-017 PREAMBLE: 7 bytes 0x55 (28 cycles Txd=01), then SFD.
REQ-018 SFD: byte 0xD5 (dibits 01,01,01,11), then DATA.
REQ-019 Tx_Ready SHALL be high for exactly one cycle: 4th dibit cycle of SFD and of every DATA byte not marked Tx_Last; low otherwise.
REQ-020 Byte accepted at Tx_Ready SHALL drive Txd starting the next cycle, no bubble.
REQ-021 Accepted byte with Tx_Last=1 ends payload: if byte count < pMIN_FRAME -> PAD, else -> FCS.
REQ-022 PAD: 0x00 bytes until payload+pad count = pMIN_FRAME, then FCS.
REQ-023 Byte counter SHALL be 11 bits, saturating at 2047; no maximum-length enforcement.
REQ-024 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF) SHALL cover payload and pad only, not preamble/SFD.
REQ-025 FCS: 4 bytes = bitwise complement of CRC register, least-significant byte first, then IFG.
REQ-026 Tx_En SHALL be high continuously from first preamble dibit through last FCS dibit.
REQ-027 IFG: Tx_En=0, Txd=00, Tx_Ready=0 for pIFG_BYTES*4 cycles, then IDLE; Tx_Valid ignored during IFG.
REQ-028 Underrun: Tx_Ready high with Tx_Valid low -> Tx_Underrun pulses that cycle, Tx_En=0/Txd=00 next cycle, CRC discarded, -> IFG.
REQ-029 Tx_Data/Tx_Last SHALL be ignored when not accepted; Tx_Valid with Tx_Busy high does not queue a frame.
REQ-030 Back-to-back frames: with Tx_Valid held, next preamble starts one cycle after IDLE is re-entered.

Reset
REQ-031 Rst low SHALL immediately force IDLE, Tx_En=0, Txd=00, Tx_Ready=0, Tx_Busy=0, Tx_Underrun=0, counters 0, CRC 0xFFFFFFFF.
REQ-032 Reset mid-frame SHALL truncate the frame with no FCS; after release, no output until a new Tx_Valid in IDLE.

Verification
REQ-033 pMIN_FRAME=0, payload ASCII "123456789" -> 28 cycles Txd=01, SFD 01,01,01,11, payload, FCS bytes 0x26,0x39,0xF4,0xCB; Tx_En high 4*(8+9+4)=84 cycles.
REQ-034 Defaults, 14-byte payload -> 46 pad bytes 0x00, FCS after byte 60; Tx_En high 4*72=288 cycles, then 48 cycles Tx_En=0 before Tx_Busy falls.
REQ-035 Defaults, 64-byte payload -> no PAD state entered; Tx_Ready pulses exactly 64 times, spaced 4 cycles.
REQ-036 Tx_Valid dropped at 5th Tx_Ready -> Tx_Underrun one pulse, Tx_En low next cycle, no FCS, IFG 48 cycles, then IDLE.
REQ-037 Rst asserted during FCS -> Tx_En/Txd 0 same cycle; two back-to-back frames after release separated by exactly 48+1 Tx_En-low cycles.
